// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle from the VGA raster counter to the renderers and pins.
// The frame_start/frame_count members exist only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
`ifdef VGA_FRAME_CNT_EN
    logic        frame_start;
    logic [15:0] frame_count;
`endif

    modport master (
        output DrawX, DrawY, blank, hs, vs
`ifdef VGA_FRAME_CNT_EN
        , output frame_start, frame_count
`endif
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs
`ifdef VGA_FRAME_CNT_EN
        , input frame_start, frame_count
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counter producing DrawX/DrawY/blank and delayed active-low hs/vs.
// Optional frame_start/frame_count outputs are built only when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY > 7 || SYNC_DELAY < 0) begin : g_param_err
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and SYNC_DELAY in 0..7");
        end
    endgenerate

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 cannot wrap.
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] draw_x_q, draw_x_d;
    logic [9:0] draw_y_q, draw_y_d;
    logic       blank_q, blank_d;
    logic       hs_raw_q, hs_raw_d;
    logic       vs_raw_q, vs_raw_d;
    logic       x_at_end, y_at_end;

    // Every registered term is derived from the next position so all of them agree in a cycle.
    always_comb begin
        x_at_end = (draw_x_q == H_LAST);
        y_at_end = (draw_y_q == V_LAST);
        draw_x_d = x_at_end ? 10'd0 : draw_x_q + 10'd1;
        draw_y_d = draw_y_q;
        if (x_at_end) begin
            draw_y_d = y_at_end ? 10'd0 : draw_y_q + 10'd1;
        end
        blank_d  = ({1'b0, draw_x_d} < H_VIS) && ({1'b0, draw_y_d} < V_VIS);
        hs_raw_d = !(({1'b0, draw_x_d} >= HS_START) && ({1'b0, draw_x_d} < HS_END));
        vs_raw_d = !(({1'b0, draw_y_d} >= VS_START) && ({1'b0, draw_y_d} < VS_END));
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            draw_x_q <= H_LAST;
            draw_y_q <= V_LAST;
            blank_q  <= 1'b0;
            hs_raw_q <= 1'b1;
            vs_raw_q <= 1'b1;
        end else begin
            draw_x_q <= draw_x_d;
            draw_y_q <= draw_y_d;
            blank_q  <= blank_d;
            hs_raw_q <= hs_raw_d;
            vs_raw_q <= vs_raw_d;
        end
    end

    assign vga.DrawX = draw_x_q;
    assign vga.DrawY = draw_y_q;
    assign vga.blank = blank_q;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign vga.hs = hs_raw_q;
            assign vga.vs = vs_raw_q;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_dly_q;
            logic [SYNC_DELAY-1:0] vs_dly_q;

            // Reset fills the line with idle-high so no stale pulse leaks out after release.
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    hs_dly_q <= '1;
                    vs_dly_q <= '1;
                end else begin
                    hs_dly_q[0] <= hs_raw_q;
                    vs_dly_q[0] <= vs_raw_q;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_dly_q[i] <= hs_dly_q[i-1];
                        vs_dly_q[i] <= vs_dly_q[i-1];
                    end
                end
            end

            assign vga.hs = hs_dly_q[SYNC_DELAY-1];
            assign vga.vs = vs_dly_q[SYNC_DELAY-1];
        end
    endgenerate

`ifdef VGA_FRAME_CNT_EN
    logic        frame_start_q;
    logic [15:0] frame_count_q;

    // The release edge also wraps (last,last)->(0,0), so the first frame counts as 1.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            frame_start_q <= (draw_x_d == 10'd0) && (draw_y_d == 10'd0);
            if (x_at_end && y_at_end) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_count_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny-raster instance checked every cycle
// against an arithmetic raster model, plus directed literal checks (frame checks under VGA_FRAME_CNT_EN).
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_q = -1;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_big ();
    vga_timing_gen_if if_small ();

    vga_timing_gen u_big (
        .vga_clk (clk),
        .reset   (reset),
        .vga     (if_big)
    );

    vga_timing_gen #(
        .H_VISIBLE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_VISIBLE (12), .V_FP (2), .V_SYNC (2), .V_BP (4),
        .SYNC_DELAY(3)
    ) u_small (
        .vga_clk (clk),
        .reset   (reset),
        .vga     (if_small)
    );

    // Edges since the last reset edge; -1 means outputs hold reset values.
    always @(posedge clk) begin
        if (reset) n_q <= -1;
        else       n_q <= n_q + 1;
    end

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    function automatic exp_t model(input int n, input int hv, input int hfp, input int hsw, input int hbp,
                                   input int vv, input int vfp, input int vsw, input int vbp, input int d);
        exp_t e;
        int ht, vt, m, xs, ys;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        e = '0;
        if (n < 0) begin
            e.x = 10'(ht - 1);
            e.y = 10'(vt - 1);
            e.hs = 1'b1;
            e.vs = 1'b1;
            return e;
        end
        e.x = 10'(n % ht);
        e.y = 10'((n / ht) % vt);
        e.blank = ((n % ht) < hv) && (((n / ht) % vt) < vv);
        m = n - d;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (m >= 0) begin
            xs = m % ht;
            ys = (m / ht) % vt;
            e.hs = !(xs >= hv + hfp && xs < hv + hfp + hsw);
            e.vs = !(ys >= vv + vfp && ys < vv + vfp + vsw);
        end
        e.fs = (n % (ht * vt)) == 0;
        e.fc = 16'((n / (ht * vt) + 1) % 65536);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s n=%0d got %0d expected %0d", name, n_q, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t eb, es;
        if (chk_en) begin
            eb = model(n_q, 640, 16, 96, 48, 480, 10, 2, 33, 2);
            es = model(n_q, 16, 4, 6, 6, 12, 2, 2, 4, 3);
            check("big.DrawX",   int'(if_big.DrawX),   int'(eb.x));
            check("big.DrawY",   int'(if_big.DrawY),   int'(eb.y));
            check("big.blank",   int'(if_big.blank),   int'(eb.blank));
            check("big.hs",      int'(if_big.hs),      int'(eb.hs));
            check("big.vs",      int'(if_big.vs),      int'(eb.vs));
            check("small.DrawX", int'(if_small.DrawX), int'(es.x));
            check("small.DrawY", int'(if_small.DrawY), int'(es.y));
            check("small.blank", int'(if_small.blank), int'(es.blank));
            check("small.hs",    int'(if_small.hs),    int'(es.hs));
            check("small.vs",    int'(if_small.vs),    int'(es.vs));
`ifdef VGA_FRAME_CNT_EN
            check("big.frame_start",   int'(if_big.frame_start),   int'(eb.fs));
            check("big.frame_count",   int'(if_big.frame_count),   int'(eb.fc));
            check("small.frame_start", int'(if_small.frame_start), int'(es.fs));
            check("small.frame_count", int'(if_small.frame_count), int'(es.fc));
`endif
        end
    end

    initial begin
        int hs_low_line1;
        int hs_low_after;
        int vs_low_cnt;
        int vs_falls;
        int vs_fall_n [2];
        logic prev_vs;

        hs_low_line1 = 0;
        hs_low_after = 0;
        vs_low_cnt = 0;
        vs_falls = 0;
        vs_fall_n[0] = -1;
        vs_fall_n[1] = -1;

        // Reset hold: three edges.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst DrawX", int'(if_big.DrawX), 799);
        check("rst DrawY", int'(if_big.DrawY), 524);
        check("rst blank", int'(if_big.blank), 0);
        check("rst hs",    int'(if_big.hs), 1);
        check("rst vs",    int'(if_big.vs), 1);
        $display("txn reset_hold DrawX=%0d DrawY=%0d", if_big.DrawX, if_big.DrawY);
        reset = 1'b0;

        // First segment: horizontal timing on the full-size raster.
        for (int k = 0; k <= 2300; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("first DrawX", int'(if_big.DrawX), 0);
                check("first DrawY", int'(if_big.DrawY), 0);
                check("first blank", int'(if_big.blank), 1);
            end
            if (k == 639) check("x639 blank", int'(if_big.blank), 1);
            if (k == 640) begin
                check("x640 DrawX", int'(if_big.DrawX), 640);
                check("x640 blank", int'(if_big.blank), 0);
            end
            if (k == 657) check("hs before fall", int'(if_big.hs), 1);
            if (k == 658) check("hs fallen",      int'(if_big.hs), 0);
            if (k == 753) check("hs last low",    int'(if_big.hs), 0);
            if (k == 754) check("hs risen",       int'(if_big.hs), 1);
            if (k == 799) check("x799 DrawX", int'(if_big.DrawX), 799);
            if (k == 800) begin
                check("wrap DrawX", int'(if_big.DrawX), 0);
                check("wrap DrawY", int'(if_big.DrawY), 1);
                check("wrap blank", int'(if_big.blank), 1);
            end
            if (k >= 800 && k < 1600 && if_big.hs == 1'b0) hs_low_line1++;
            if (k == 2300) check("hs low before reset", int'(if_big.hs), 0);
        end
        check("hs low width line1", hs_low_line1, 96);
        $display("txn line_timing hs_low_cycles=%0d", hs_low_line1);

        // Mid-line reset while the hs delay line holds zeros.
        reset = 1'b1;
        @(negedge clk);
        check("midrst DrawX", int'(if_big.DrawX), 799);
        check("midrst DrawY", int'(if_big.DrawY), 524);
        check("midrst blank", int'(if_big.blank), 0);
        check("midrst hs",    int'(if_big.hs), 1);
        $display("txn mid_reset DrawX=%0d hs=%0d", if_big.DrawX, if_big.hs);
        reset = 1'b0;

        // Second segment: no stale hs, vertical timing and frames on the tiny raster.
        prev_vs = 1'b1;
        for (int k = 0; k < 1400; k++) begin
            @(negedge clk);
            if (k < 650 && if_big.hs == 1'b0) hs_low_after++;
            if (k < 640 && if_small.vs == 1'b0) vs_low_cnt++;
            if (prev_vs == 1'b1 && if_small.vs == 1'b0 && vs_falls < 2) begin
                vs_fall_n[vs_falls] = k;
                vs_falls++;
            end
            prev_vs = if_small.vs;
            if (k == 439) begin
                check("small blanked-line hs", int'(if_small.hs), 0);
                check("small blanked-line blank", int'(if_small.blank), 0);
            end
`ifdef VGA_FRAME_CNT_EN
            if (k == 0 || k == 640 || k == 1280) begin
                check("frame_start pulse", int'(if_small.frame_start), 1);
                $display("txn frame_start k=%0d frame_count=%0d", k, if_small.frame_count);
            end
            if (k == 1) check("frame_start low", int'(if_small.frame_start), 0);
            if (k == 1280) check("frame_count third", int'(if_small.frame_count), 3);
`endif
        end
        check("no stale hs after reset", hs_low_after, 0);
        check("small vs low width", vs_low_cnt, 64);
        check("small vs first fall", vs_fall_n[0], 451);
        check("small vs period", vs_fall_n[1] - vs_fall_n[0], 640);
        $display("txn vsync falls=%0d first=%0d second=%0d low=%0d", vs_falls, vs_fall_n[0], vs_fall_n[1], vs_low_cnt);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
